wb_port_arbiter: RTL and testbench

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

---
 rtl/wb_port_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_wb_port_arbiter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: two-source register-file write-back port arbiter.
// Load path normally wins a conflict; an ALU request that has been stalled
// for STARVE_LIMIT consecutive cycles is force-granted on the next cycle.
// Optional feature macro: WB_BYPASS_EN adds fwd_valid/fwd_reg/fwd_data,
// which combinationally mirror the transfer granted in the current cycle.
module wb_port_arbiter #(
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_valid,
  input  logic [4:0]        alu_reg,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              ld_valid,
  input  logic [4:0]        ld_reg,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  output logic              write_enable,
  output logic [4:0]        write_reg,
  output logic [DATA_W-1:0] write_data,
  output logic              grant_src,
  output logic              write_back_done
`ifdef WB_BYPASS_EN
  ,
  output logic              fwd_valid,
  output logic [4:0]        fwd_reg,
  output logic [DATA_W-1:0] fwd_data
`endif
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [0:0] {
    ST_NORMAL    = 1'b0,
    ST_FORCE_ALU = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          starve_q, starve_d;
  logic                write_enable_q, write_enable_d;
  logic [4:0]          write_reg_q, write_reg_d;
  logic [DATA_W-1:0]   write_data_q, write_data_d;
  logic                grant_src_q, grant_src_d;
  logic                done_q, done_d;

  logic                alu_win_s;
  logic                ld_win_s;
  logic                xfer_s;
  logic [4:0]          sel_reg_s;
  logic [DATA_W-1:0]   sel_data_s;

  // Pick the winning requester for this cycle from the current mode.
  always_comb begin
    alu_win_s = 1'b0;
    ld_win_s  = 1'b0;
    if (reset) begin
      alu_win_s = 1'b0;
      ld_win_s  = 1'b0;
    end else begin
      case (state_q)
        ST_FORCE_ALU: begin
          alu_win_s = alu_valid;
          ld_win_s  = ld_valid & ~alu_valid;
        end
        ST_NORMAL: begin
          ld_win_s  = ld_valid;
          alu_win_s = alu_valid & ~ld_valid;
        end
        default: begin
          ld_win_s  = ld_valid;
          alu_win_s = alu_valid & ~ld_valid;
        end
      endcase
    end
  end

  assign alu_ready = alu_win_s;
  assign ld_ready  = ld_win_s;
  assign xfer_s    = alu_win_s | ld_win_s;

  // Mux the granted request's destination and payload.
  always_comb begin
    sel_reg_s  = 5'd0;
    sel_data_s = '0;
    if (ld_win_s) begin
      sel_reg_s  = ld_reg;
      sel_data_s = ld_data;
    end else if (alu_win_s) begin
      sel_reg_s  = alu_reg;
      sel_data_s = alu_data;
    end else begin
      sel_reg_s  = 5'd0;
      sel_data_s = '0;
    end
  end

  // Next-state: starvation counter, mode, and the registered write port.
  always_comb begin
    starve_d       = 4'd0;
    state_d        = state_q;
    write_enable_d = 1'b0;
    write_reg_d    = 5'd0;
    write_data_d   = '0;
    grant_src_d    = grant_src_q;
    done_d         = 1'b0;

    // Count consecutive stalled ALU cycles, saturating at the limit.
    if (alu_valid && !alu_win_s) begin
      if (starve_q >= LIMIT) begin
        starve_d = LIMIT;
      end else begin
        starve_d = starve_q + 4'd1;
      end
    end else begin
      starve_d = 4'd0;
    end

    case (state_q)
      ST_NORMAL: begin
        if (starve_d >= LIMIT) begin
          state_d = ST_FORCE_ALU;
        end else begin
          state_d = ST_NORMAL;
        end
      end
      ST_FORCE_ALU: begin
        if (!alu_valid || alu_win_s) begin
          state_d = ST_NORMAL;
        end else begin
          state_d = ST_FORCE_ALU;
        end
      end
      default: begin
        state_d = ST_NORMAL;
      end
    endcase

    // Writes to x0 are acknowledged but never strobe the register file.
    if (xfer_s) begin
      done_d      = 1'b1;
      grant_src_d = ld_win_s;
      if (sel_reg_s != 5'd0) begin
        write_enable_d = 1'b1;
        write_reg_d    = sel_reg_s;
        write_data_d   = sel_data_s;
      end else begin
        write_enable_d = 1'b0;
        write_reg_d    = 5'd0;
        write_data_d   = '0;
      end
    end else begin
      done_d      = 1'b0;
      grant_src_d = grant_src_q;
    end
  end

  // Arbiter state and registered write-back outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_NORMAL;
      starve_q       <= 4'd0;
      write_enable_q <= 1'b0;
      write_reg_q    <= 5'd0;
      write_data_q   <= '0;
      grant_src_q    <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      starve_q       <= starve_d;
      write_enable_q <= write_enable_d;
      write_reg_q    <= write_reg_d;
      write_data_q   <= write_data_d;
      grant_src_q    <= grant_src_d;
      done_q         <= done_d;
    end
  end

  assign write_enable    = write_enable_q;
  assign write_reg       = write_reg_q;
  assign write_data      = write_data_q;
  assign grant_src       = grant_src_q;
  assign write_back_done = done_q;

`ifdef WB_BYPASS_EN
  assign fwd_valid = xfer_s & (sel_reg_s != 5'd0);
  assign fwd_reg   = fwd_valid ? sel_reg_s : 5'd0;
  assign fwd_data  = fwd_valid ? sel_data_s : '0;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: a stimulus process predicts each
// transfer from a waiting-cycle model and queues the expected write; a
// monitor pops the queue whenever write_back_done pulses.
module tb_wb_port_arbiter;
  localparam int DW    = 32;
  localparam int LIMIT = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          alu_valid = 1'b0;
  logic [4:0]    alu_reg = 5'd0;
  logic [DW-1:0] alu_data = '0;
  logic          alu_ready;
  logic          ld_valid = 1'b0;
  logic [4:0]    ld_reg = 5'd0;
  logic [DW-1:0] ld_data = '0;
  logic          ld_ready;
  logic          write_enable;
  logic [4:0]    write_reg;
  logic [DW-1:0] write_data;
  logic          grant_src;
  logic          write_back_done;
`ifdef WB_BYPASS_EN
  logic          fwd_valid;
  logic [4:0]    fwd_reg;
  logic [DW-1:0] fwd_data;
`endif

  wb_port_arbiter #(.DATA_W(DW), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data), .alu_ready(alu_ready),
    .ld_valid(ld_valid), .ld_reg(ld_reg), .ld_data(ld_data), .ld_ready(ld_ready),
    .write_enable(write_enable), .write_reg(write_reg), .write_data(write_data),
    .grant_src(grant_src), .write_back_done(write_back_done)
`ifdef WB_BYPASS_EN
    , .fwd_valid(fwd_valid), .fwd_reg(fwd_reg), .fwd_data(fwd_data)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int            tag;
    logic [4:0]    r;
    logic [DW-1:0] d;
    logic          src;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   waited = 0;
  logic exp_gsrc = 1'b0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // One stimulus cycle: drive, predict the winner, check readies, queue the write.
  task automatic drive(input logic av, input logic [4:0] ar, input logic [DW-1:0] ad,
                       input logic lv, input logic [4:0] lr, input logic [DW-1:0] ldv,
                       input logic rs, output logic a_acc, output logic l_acc);
    logic ea, el;
    exp_t e;
    @(negedge clk);
    alu_valid = av; alu_reg = ar; alu_data = ad;
    ld_valid = lv;  ld_reg = lr;  ld_data = ldv;
    reset = rs;
    #1;
    if (rs) begin
      ea = 1'b0;
      el = 1'b0;
    end else begin
      ea = av && (!lv || waited >= LIMIT);
      el = lv && !ea;
    end
    chk("alu_ready", {31'd0, alu_ready}, {31'd0, ea});
    chk("ld_ready", {31'd0, ld_ready}, {31'd0, el});
    if (ea || el) begin
      e.tag = cyc + 1;
      e.r   = el ? lr : ar;
      e.d   = el ? ldv : ad;
      e.src = el;
      q.push_back(e);
    end
`ifdef WB_BYPASS_EN
    chk("fwd_valid", {31'd0, fwd_valid}, {31'd0, (ea || el) && ((el ? lr : ar) != 5'd0)});
    if ((ea || el) && ((el ? lr : ar) != 5'd0)) begin
      chk("fwd_reg", {27'd0, fwd_reg}, {27'd0, (el ? lr : ar)});
      chk("fwd_data", fwd_data, (el ? ldv : ad));
    end
`endif
    if (rs || !(av && !ea)) waited = 0;
    else if (waited < LIMIT) waited++;
    a_acc = ea;
    l_acc = el;
  endtask

  // Monitor: compare the registered write port one step after each edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    cyc++;
    if (reset) begin
      chk("rst_we", {31'd0, write_enable}, 32'd0);
      chk("rst_reg", {27'd0, write_reg}, 32'd0);
      chk("rst_data", write_data, 32'd0);
      chk("rst_gsrc", {31'd0, grant_src}, 32'd0);
      chk("rst_done", {31'd0, write_back_done}, 32'd0);
      exp_gsrc = 1'b0;
    end else if (write_back_done) begin
      if (q.size() == 0) begin
        total++; bad++;
        $display("FAIL spurious_done: got 1 expected 0 (cycle %0d)", cyc);
      end else begin
        e = q.pop_front();
        chk("wb_cycle", cyc, e.tag);
        chk("wb_we", {31'd0, write_enable}, {31'd0, e.r != 5'd0});
        chk("wb_reg", {27'd0, write_reg}, {27'd0, e.r});
        chk("wb_data", write_data, (e.r != 5'd0) ? e.d : 32'd0);
        chk("wb_gsrc", {31'd0, grant_src}, {31'd0, e.src});
        exp_gsrc = e.src;
      end
    end else begin
      chk("idle_we", {31'd0, write_enable}, 32'd0);
      chk("idle_reg", {27'd0, write_reg}, 32'd0);
      chk("idle_data", write_data, 32'd0);
      chk("idle_gsrc", {31'd0, grant_src}, {31'd0, exp_gsrc});
      if (q.size() > 0 && q[0].tag <= cyc) begin
        e = q.pop_front();
        total++; bad++;
        $display("FAIL missed_done: got 0 expected 1 for r%0d (cycle %0d)", e.r, cyc);
      end
    end
  end

  initial begin
    logic aa, la, pa, pl, rs;
    logic [4:0] ar, lr;
    logic [DW-1:0] ad, ldv;
    int first;
    // reset hold
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, aa, la);
    drive(1'b1, 5'd1, 32'd1, 1'b1, 5'd2, 32'd2, 1'b1, aa, la);
    // ALU only
    drive(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0, 1'b0, aa, la);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, aa, la);
    // conflict: load first, ALU next
    drive(1'b1, 5'd7, 32'hBB, 1'b1, 5'd3, 32'hAA, 1'b0, aa, la);
    drive(1'b1, 5'd7, 32'hBB, 1'b0, 5'd0, 32'd0, 1'b0, aa, la);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, aa, la);
    // starvation: ALU held, loads continuous
    first = 0;
    for (int i = 1; i <= 7; i++) begin
      drive(first == 0, 5'd9, 32'h55, 1'b1, 5'(10 + i), 32'(i), 1'b0, aa, la);
      if (alu_ready && first == 0) first = i;
      if (i == first + 1 && first != 0) chk("ld_after_force", {31'd0, ld_ready}, 32'd1);
    end
    chk("starve_grant_cycle", first, 5);
    // x0 write
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFF, 1'b0, aa, la);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, aa, la);
    // reset mid-stream
    for (int i = 0; i < 3; i++) drive(1'b1, 5'd4, 32'h44, 1'b1, 5'(20 + i), 32'(i), 1'b0, aa, la);
    drive(1'b1, 5'd4, 32'h44, 1'b1, 5'd23, 32'h23, 1'b1, aa, la);
    drive(1'b1, 5'd4, 32'h44, 1'b1, 5'd24, 32'h24, 1'b0, aa, la);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, aa, la);
    // randomized traffic with held requests
    pa = 1'b0; pl = 1'b0; ar = 5'd0; lr = 5'd0; ad = '0; ldv = '0;
    for (int i = 0; i < 1500; i++) begin
      if (!pa && $urandom_range(0, 2) != 0) begin
        pa = 1'b1; ar = 5'($urandom_range(0, 31)); ad = $urandom;
      end
      if (!pl && $urandom_range(0, 4) != 0) begin
        pl = 1'b1; lr = 5'($urandom_range(0, 31)); ldv = $urandom;
      end
      rs = ($urandom_range(0, 99) == 0);
      drive(pa, ar, ad, pl, lr, ldv, rs, aa, la);
      if (aa) pa = 1'b0;
      if (la) pl = 1'b0;
    end
    for (int i = 0; i < 3; i++) drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, aa, la);
    chk("queue_empty", q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
